seq_check: RTL and testbench

// - Checker for nibble sequences; the receive-side counterpart of the string-driven nibble sequence generator.
// - Compares a 4-bit stream (din/valid) against a parameter string, one character per valid beat.
// - Reports pass/fail, mismatch count and first mismatch index.
// - Sits in demo benches next to the DUT output or the generator so properties can observe a compact verdict.
//

---
 rtl/seq_check.sv | 99 +++++++++
 tb/tb_seq_check.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_check.sv
// seq_check: compares a valid-qualified nibble stream against a parameter string and reports a verdict.
// Define SEQ_CHECK_ASSERT_EN to add an immediate assertion that fires on every mismatching beat.
module seq_check #(
    parameter logic [1023:0] SEQ    = "",
    parameter int            SEQLEN = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] din,
    input  logic       valid,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [7:0] err_count,
    output logic [7:0] first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] LAST = 8'(SEQLEN - 1);

    state_t     state;
    logic [7:0] idx;
    logic [7:0] cur_char;
    logic       care;
    logic [3:0] exp_nib;
    logic       mismatch;
    logic [7:0] err_next;

    // Returns {care, value}; bytes outside the recognised set are don't-care.
    function automatic logic [4:0] decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0_0000;
        if (c >= "0" && c <= "9")
            r = {1'b1, c[3:0]};
        else if ((c >= "A" && c <= "F") || (c >= "a" && c <= "f"))
            r = {1'b1, c[3:0] + 4'd9};
        else if (c == "_")
            r = 5'b1_0000;
        else if (c == "-")
            r = 5'b1_1111;
        return r;
    endfunction

    // NOTE: every signal here is assigned on every pass, so no latch is inferred.
    always_comb begin
        cur_char        = 8'(SEQ >> {LAST - idx, 3'b000});
        {care, exp_nib} = decode(cur_char);
        mismatch        = care && (din !== exp_nib);
        err_next        = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            err_count     <= 8'd0;
            first_err_idx <= 8'd0;
        end else if (start) begin
            // A beat arriving together with start is deliberately dropped.
            state         <= RUN;
            idx           <= 8'd0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            err_count     <= 8'd0;
            first_err_idx <= 8'd0;
        end else if (state == RUN && valid) begin
            idx       <= idx + 8'd1;
            err_count <= err_next;
            if (mismatch && err_count == 8'd0)
                first_err_idx <= idx;
            if (idx == LAST) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next == 8'd0);
                fail  <= (err_next != 8'd0);
            end
        end
    end

`ifdef SEQ_CHECK_ASSERT_EN
    always_ff @(posedge clock) begin
        if (!reset && busy && valid)
            assert (!mismatch)
            else $error("seq_check: mismatch at idx %0d", idx);
    end
`endif

endmodule

// File: tb/tb_seq_check.sv
// Self-checking bench for seq_check: four instances with different strings, directed and random
// stimulus, compared each cycle against a beat-list reference model.
module tb_seq_check;

    localparam int N = 4;
    localparam int LENS [N] = '{4, 3, 11, 1};

    string seqs [N] = '{"12_F", "1x3", "09afAF_-xZ?", "5"};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start [N];
    logic       valid [N];
    logic [3:0] din [N];
    logic       busy [N];
    logic       done [N];
    logic       pass [N];
    logic       fail [N];
    logic [7:0] err_count [N];
    logic [7:0] first_err_idx [N];

    int checks   = 0;
    int failures = 0;

    // Reference model: the list of beats accepted since the last start.
    logic       started [N];
    int         cnt [N];
    logic [3:0] beats [N][128];

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam logic [1023:0] S = (g == 0) ? 1024'("12_F") :
                                      (g == 1) ? 1024'("1x3") :
                                      (g == 2) ? 1024'("09afAF_-xZ?") : 1024'("5");
        seq_check #(.SEQ(S), .SEQLEN(LENS[g])) u_dut (
            .clock        (clock),
            .reset        (reset),
            .start        (start[g]),
            .din          (din[g]),
            .valid        (valid[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .pass         (pass[g]),
            .fail         (fail[g]),
            .err_count    (err_count[g]),
            .first_err_idx(first_err_idx[g])
        );
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected nibble of a character, or -1 for don't-care.
    function automatic int ref_val(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - int'("0");
        if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
        if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
        if (c == "_") return 0;
        if (c == "-") return 15;
        return -1;
    endfunction

    function automatic logic [3:0] good_nib(input int k, input int i);
        int r;
        r = ref_val(seqs[k][i]);
        return (r < 0) ? 4'($urandom) : 4'(r);
    endfunction

    task automatic check_all();
        int   errs;
        int   first;
        int   r;
        logic dn;
        logic by;
        for (int k = 0; k < N; k++) begin
            errs  = 0;
            first = -1;
            for (int i = 0; i < cnt[k]; i++) begin
                r = ref_val(seqs[k][i]);
                if (r >= 0 && beats[k][i] !== 4'(r)) begin
                    errs++;
                    if (first < 0) first = i;
                end
            end
            if (errs > 255) errs = 255;
            dn = started[k] && (cnt[k] == LENS[k]);
            by = started[k] && (cnt[k] < LENS[k]);
            check($sformatf("busy%0d", k), 8'(busy[k]), 8'(by));
            check($sformatf("done%0d", k), 8'(done[k]), 8'(dn));
            check($sformatf("pass%0d", k), 8'(pass[k]), 8'(dn && errs == 0));
            check($sformatf("fail%0d", k), 8'(fail[k]), 8'(dn && errs != 0));
            check($sformatf("err_count%0d", k), err_count[k], 8'(errs));
            check($sformatf("first_err_idx%0d", k), first_err_idx[k], 8'((first < 0) ? 0 : first));
        end
    endtask

    // One clock cycle: drive DUT k, update the model at the edge, check every DUT on the falling edge.
    task automatic cyc(input int k, input logic st, input logic v, input logic [3:0] d);
        for (int j = 0; j < N; j++) begin
            start[j] = 1'b0;
            valid[j] = 1'b0;
            din[j]   = 4'($urandom);
        end
        start[k] = st;
        valid[k] = v;
        din[k]   = d;
        @(posedge clock);
        for (int j = 0; j < N; j++) begin
            if (reset) begin
                started[j] = 1'b0;
                cnt[j]     = 0;
            end else if (start[j]) begin
                started[j] = 1'b1;
                cnt[j]     = 0;
            end else if (started[j] && cnt[j] < LENS[j] && valid[j]) begin
                beats[j][cnt[j]] = din[j];
                cnt[j]++;
            end
        end
        @(negedge clock);
        check_all();
    endtask

    task automatic run_good(input int k);
        cyc(k, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < LENS[k]; i++) cyc(k, 1'b0, 1'b1, good_nib(k, i));
        cyc(k, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        logic [3:0] gap_data [4];
        logic       gap_valid [7];
        int         bi;
        int         k;
        logic       st;
        logic       v;
        logic [3:0] d;

        gap_data  = '{4'h1, 4'h2, 4'h0, 4'hF};
        gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset, with start held high during it (must be ignored).
        cyc(0, 1'b1, 1'b1, 4'h1);
        cyc(0, 1'b0, 1'b0, 4'h0);
        reset = 1'b0;
        cyc(0, 1'b0, 1'b1, 4'h1);

        // "12_F": correct stream, then extra valid beats while DONE.
        run_good(0);
        cyc(0, 1'b0, 1'b1, 4'h3);
        cyc(0, 1'b0, 1'b1, 4'h9);

        // "12_F": 1,3,0,E -> two errors, first at index 1.
        cyc(0, 1'b1, 1'b0, 4'h0);
        cyc(0, 1'b0, 1'b1, 4'h1);
        cyc(0, 1'b0, 1'b1, 4'h3);
        cyc(0, 1'b0, 1'b1, 4'h0);
        cyc(0, 1'b0, 1'b1, 4'hE);
        cyc(0, 1'b0, 1'b0, 4'h0);

        // "1x3": 1,7,3 passes through the don't-care.
        cyc(1, 1'b1, 1'b0, 4'h0);
        cyc(1, 1'b0, 1'b1, 4'h1);
        cyc(1, 1'b0, 1'b1, 4'h7);
        cyc(1, 1'b0, 1'b1, 4'h3);
        cyc(1, 1'b0, 1'b0, 4'h0);

        // "12_F" with gaps in valid.
        cyc(0, 1'b1, 1'b0, 4'h0);
        bi = 0;
        for (int i = 0; i < 7; i++) begin
            if (gap_valid[i]) begin
                cyc(0, 1'b0, 1'b1, gap_data[bi]);
                bi++;
            end else begin
                cyc(0, 1'b0, 1'b0, 4'($urandom));
            end
        end
        cyc(0, 1'b0, 1'b0, 4'h0);

        // Reset after two beats, then a clean pass.
        cyc(0, 1'b1, 1'b0, 4'h0);
        cyc(0, 1'b0, 1'b1, 4'h1);
        cyc(0, 1'b0, 1'b1, 4'h2);
        reset = 1'b1;
        cyc(0, 1'b0, 1'b1, 4'h0);
        reset = 1'b0;
        cyc(0, 1'b0, 1'b1, 4'hF);
        run_good(0);

        // Mismatch at index 0, restart mid-run (beat with start is dropped), then a clean pass.
        cyc(0, 1'b1, 1'b0, 4'h0);
        cyc(0, 1'b0, 1'b1, 4'h9);
        cyc(0, 1'b0, 1'b1, 4'h2);
        cyc(0, 1'b1, 1'b1, 4'h7);
        for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b1, good_nib(0, i));
        cyc(0, 1'b0, 1'b0, 4'h0);

        // Full decode table, including an x on a cared character.
        run_good(2);
        cyc(2, 1'b1, 1'b0, 4'h0);
        cyc(2, 1'b0, 1'b1, 4'h0);
        cyc(2, 1'b0, 1'b1, 4'bxxxx);
        for (int i = 2; i < LENS[2]; i++) cyc(2, 1'b0, 1'b1, good_nib(2, i));

        // Single-character string: one beat finishes the pass.
        run_good(3);
        cyc(3, 1'b1, 1'b0, 4'h0);
        cyc(3, 1'b0, 1'b1, 4'h4);
        cyc(3, 1'b0, 1'b0, 4'h0);

        // Random traffic across all instances.
        repeat (600) begin
            k  = $urandom_range(0, N - 1);
            st = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if (cnt[k] < LENS[k] && $urandom_range(0, 3) != 0)
                d = good_nib(k, cnt[k]);
            else
                d = 4'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            cyc(k, st, v, d);
        end
        reset = 1'b0;
        for (int j = 0; j < N; j++) run_good(j);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
